cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/step sequencer for the single-cycle RIJ CPU on the board top.
- Turns debounced push-button levels into a one-cycle CPU clock-enable pulse (`cpu_ce`), either on demand (single step) or periodically (run mode).
- In run mode it halts on a PC breakpoint or on overflow.
- Exposes state and an executed-instruction count so the switch-selected LED mux can display them.

Parameters:
- RUN_DIV, 50_000_000: clk_100MHz cycles between successive `cpu_ce` pulses in run mode; minimum 2.
- CNT_W, 32: width of `instr_cnt`.

Ports:
- clk_100MHz  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- step_btn  in  1  debounced step button level, asynchronous to clk
- run_btn  in  1  debounced run/pause button level, asynchronous to clk
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC value
- halt_on_of  in  1  enable halt on overflow
- pc  in  32  current CPU PC
- of  in  1  CPU overflow flag (OF)
- cpu_ce  out  1  one-cycle CPU advance enable
- state  out  2  00 IDLE, 01 RUN, 10 BRK, 11 unused
- brk_cause  out  2  00 none, 01 breakpoint, 10 overflow
- instr_cnt  out  CNT_W  count of `cpu_ce` pulses issued

Behaviour:
- Reset (async, `rst` = 1): all flops clear. `cpu_ce` = 0, `state` = IDLE, `brk_cause` = 00, `instr_cnt` = 0, divider = 0. Reset mid-run aborts immediately and no `cpu_ce` pulse follows.
- Input synchronisation: `step_btn` and `run_btn` each pass through a 2-flop synchroniser plus a delay flop.
  - `step_ev` = s2 & ~s3; `run_ev` = s2 & ~s3 (rising edges only).
  - A held button produces exactly one event.
- Outputs `cpu_ce`, `state` and `brk_cause` are registered.
- Event priority:
  - If `run_ev` and `step_ev` occur in the same cycle, `run_ev` wins and `step_ev` is dropped.
- IDLE:
  - `step_ev`: `cpu_ce` = 1 for the next cycle only; remain in IDLE.
  - `run_ev`: go to RUN; divider = 0; set `first_tick` = 1.
- RUN:
  - The divider counts 0..RUN_DIV-1. A tick occurs when divider == RUN_DIV-1; the divider then wraps to 0.
  - On a tick with `first_tick` = 1: issue `cpu_ce` and clear `first_tick`. No halt checks apply, so execution can resume from a breakpoint PC.
  - On a tick with `first_tick` = 0, check in this order:
    - `halt_on_of` & `of`: go to BRK, `brk_cause` = 10, no `cpu_ce`.
    - Else `bp_en` & (`pc` == `bp_addr`): go to BRK, `brk_cause` = 01, no `cpu_ce`.
    - Else issue `cpu_ce`.
  - `run_ev`: go to IDLE (pause); divider cleared; no `cpu_ce` that cycle even if it coincides with a tick.
  - `step_ev` is ignored in RUN.
- BRK:
  - `step_ev`: issue one `cpu_ce`; stay in BRK; `brk_cause` held.
  - `run_ev`: go to RUN; `brk_cause` = 00; divider = 0; `first_tick` = 1.
- `cpu_ce` is never high for two consecutive cycles. It goes high only in the cycle after the deciding event or tick.
- `instr_cnt` increments by 1 in the cycle `cpu_ce` is high and saturates at all-ones (no wrap).
- Latency:
  - From a button level sampled high to `cpu_ce` high is exactly 4 clk edges (2 sync + edge + output register).
  - From a RUN tick to `cpu_ce` high is 1 cycle.

Decomposition:
- Shared package (`cpu_dbg_pkg`) holds:
  - state encodings IDLE/RUN/BRK;
  - `brk_cause` encodings;
  - a `DBG_PC_W` = 32 constant.
- One natural sub-module: `btn_sync_edge` (2-flop synchroniser + rising-edge pulse), instantiated twice.
- FSM, divider and counter stay in the top of the block.

Test Plan:
- Reset, then `step_btn` held high for 20 cycles -> exactly one `cpu_ce` pulse, 4 edges after the first high sample; `instr_cnt` = 1; `state` = 00.
- RUN_DIV = 4, press run, `bp_en` = 0 -> `cpu_ce` every 4th cycle; after 10 pulses `instr_cnt` = 10; press run again -> `state` = 00 and no further pulses.
- RUN_DIV = 4, `bp_en` = 1, `bp_addr` = 0x0000000C, `pc` stepping 0, 4, 8, C on each `cpu_ce` -> 3 pulses, then `state` = 10, `brk_cause` = 01. Press run -> one pulse at PC = C, then running resumes.
- `halt_on_of` = 1 with `of` forced high during RUN (not first tick) -> `state` = 10, `brk_cause` = 10, no `cpu_ce` on that tick. A step in BRK -> exactly one `cpu_ce`.
- `run_btn` and `step_btn` rise in the same cycle from IDLE -> enters RUN; no immediate step pulse.
- Assert `rst` mid-RUN one cycle before a tick -> `cpu_ce` stays 0; all outputs zero asynchronously. CNT_W = 4 with 20 steps -> `instr_cnt` saturates at 0xF.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run/step debug controller and its LED mux.
package cpu_dbg_pkg;

    localparam int DBG_PC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_BRK  = 2'b10
    } run_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_BP   = 2'b01,
        CAUSE_OF   = 2'b10
    } brk_cause_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a debounced button level, followed by a
// registered one-cycle pulse on its rising edge.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);

    logic s1_r;
    logic s2_r;
    logic s3_r;
    logic ev_r;

    // Synchroniser chain, delay flop and registered edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
            ev_r <= 1'b0;
        end else begin
            s1_r <= btn;
            s2_r <= s1_r;
            s3_r <= s2_r;
            ev_r <= s2_r & ~s3_r;
        end
    end

    assign ev = ev_r;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: turns button edges into single-cycle CPU clock enables,
// either on demand or periodically, halting on breakpoint or overflow.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int RUN_DIV = 50_000_000,
    parameter int CNT_W   = 32
) (
    input  logic                clk_100MHz,
    input  logic                rst,
    input  logic                step_btn,
    input  logic                run_btn,
    input  logic                bp_en,
    input  logic [DBG_PC_W-1:0] bp_addr,
    input  logic                halt_on_of,
    input  logic [DBG_PC_W-1:0] pc,
    input  logic                of,
    output logic                cpu_ce,
    output logic [1:0]          state,
    output logic [1:0]          brk_cause,
    output logic [CNT_W-1:0]    instr_cnt
);

    localparam int DIV_W = $clog2(RUN_DIV);

    logic             step_ev_s;
    logic             run_ev_s;
    logic             tick_s;
    logic             bp_hit_s;
    logic             of_hit_s;
    run_state_e       state_r;
    brk_cause_e       cause_r;
    logic             ce_r;
    logic             first_tick_r;
    logic [DIV_W-1:0] div_r;
    logic [CNT_W-1:0] cnt_r;

    btn_sync_edge u_step_sync (
        .clk (clk_100MHz),
        .rst (rst),
        .btn (step_btn),
        .ev  (step_ev_s)
    );

    btn_sync_edge u_run_sync (
        .clk (clk_100MHz),
        .rst (rst),
        .btn (run_btn),
        .ev  (run_ev_s)
    );

    assign tick_s   = (div_r == DIV_W'(RUN_DIV - 1));
    assign bp_hit_s = bp_en & (pc == bp_addr);
    assign of_hit_s = halt_on_of & of;

    // Run/step state machine with divider and registered outputs
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cause_r      <= CAUSE_NONE;
            ce_r         <= 1'b0;
            first_tick_r <= 1'b0;
            div_r        <= {DIV_W{1'b0}};
        end else begin
            ce_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    div_r <= {DIV_W{1'b0}};
                    if (run_ev_s) begin
                        state_r      <= ST_RUN;
                        first_tick_r <= 1'b1;
                    end else if (step_ev_s) begin
                        ce_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_ev_s) begin
                        state_r <= ST_IDLE;
                        div_r   <= {DIV_W{1'b0}};
                    end else if (tick_s) begin
                        div_r <= {DIV_W{1'b0}};
                        // The first tick after (re)starting skips halt checks so a
                        // breakpoint PC can be stepped past.
                        if (first_tick_r) begin
                            ce_r         <= 1'b1;
                            first_tick_r <= 1'b0;
                        end else if (of_hit_s) begin
                            state_r <= ST_BRK;
                            cause_r <= CAUSE_OF;
                        end else if (bp_hit_s) begin
                            state_r <= ST_BRK;
                            cause_r <= CAUSE_BP;
                        end else begin
                            ce_r <= 1'b1;
                        end
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_BRK: begin
                    div_r <= {DIV_W{1'b0}};
                    if (run_ev_s) begin
                        state_r      <= ST_RUN;
                        cause_r      <= CAUSE_NONE;
                        first_tick_r <= 1'b1;
                    end else if (step_ev_s) begin
                        ce_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cause_r      <= CAUSE_NONE;
                    first_tick_r <= 1'b0;
                    div_r        <= {DIV_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of issued clock enables
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (ce_r && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign cpu_ce    = ce_r;
    assign state     = state_r;
    assign brk_cause = cause_r;
    assign instr_cnt = cnt_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: vector table for button edge timing plus
// hand-written run, breakpoint, overflow, reset and saturation sequences.
module tb_cpu_run_ctrl;

    logic        clk_100MHz = 1'b0;
    logic        rst;
    logic        step_btn;
    logic        run_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        halt_on_of;
    logic [31:0] pc;
    logic        of;
    logic        cpu_ce;
    logic [1:0]  state;
    logic [1:0]  brk_cause;
    logic [31:0] instr_cnt;
    logic        cpu_ce4;
    logic [1:0]  state4;
    logic [1:0]  brk_cause4;
    logic [3:0]  instr_cnt4;

    int checks   = 0;
    int failures = 0;
    int ce_seen  = 0;
    logic ce_prev = 1'b0;

    typedef struct packed {
        logic       step;
        logic       run;
        logic       exp_ce;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tbl [34];

    always #5 clk_100MHz = ~clk_100MHz;

    cpu_run_ctrl #(.RUN_DIV(4), .CNT_W(32)) dut (
        .clk_100MHz (clk_100MHz), .rst (rst), .step_btn (step_btn), .run_btn (run_btn),
        .bp_en (bp_en), .bp_addr (bp_addr), .halt_on_of (halt_on_of), .pc (pc), .of (of),
        .cpu_ce (cpu_ce), .state (state), .brk_cause (brk_cause), .instr_cnt (instr_cnt)
    );

    cpu_run_ctrl #(.RUN_DIV(4), .CNT_W(4)) dut4 (
        .clk_100MHz (clk_100MHz), .rst (rst), .step_btn (step_btn), .run_btn (run_btn),
        .bp_en (bp_en), .bp_addr (bp_addr), .halt_on_of (halt_on_of), .pc (pc), .of (of),
        .cpu_ce (cpu_ce4), .state (state4), .brk_cause (brk_cause4), .instr_cnt (instr_cnt4)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge; the CPU model advances pc
    // on the edge where cpu_ce was high.
    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
        if (ce_prev) pc = pc + 32'd4;
        ce_prev = cpu_ce;
        if (cpu_ce) ce_seen++;
    endtask

    task automatic wait_ce(input int max, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < max) begin
            cyc();
            n++;
            if (cpu_ce) found = 1'b1;
        end
        check("wait_ce_timeout", {31'd0, found}, 32'd1);
    endtask

    task automatic press_run();
        run_btn = 1'b1;
        repeat (3) cyc();
        run_btn = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic press_step();
        step_btn = 1'b1;
        repeat (3) cyc();
        step_btn = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        int n;
        rst = 1'b1; step_btn = 1'b0; run_btn = 1'b0; bp_en = 1'b0;
        bp_addr = 32'h0000_000C; halt_on_of = 1'b0; pc = 32'd0; of = 1'b0;

        // Table: step held 20 cycles, release, then run+step rising together
        for (int i = 0; i < 34; i++) begin
            if (i < 20) begin
                tbl[i] = '{step: 1'b1, run: 1'b0, exp_ce: (i == 3), exp_state: 2'b00};
            end else if (i < 24) begin
                tbl[i] = '{step: 1'b0, run: 1'b0, exp_ce: 1'b0, exp_state: 2'b00};
            end else begin
                tbl[i] = '{step: 1'b1, run: 1'b1, exp_ce: ((i - 24) == 7),
                           exp_state: ((i - 24) >= 3) ? 2'b01 : 2'b00};
            end
        end

        repeat (3) @(posedge clk_100MHz);
        #1;
        check("reset_ce", {31'd0, cpu_ce}, 32'd0);
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_cause", {30'd0, brk_cause}, 32'd0);
        check("reset_cnt", instr_cnt, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            step_btn = tbl[i].step;
            run_btn  = tbl[i].run;
            cyc();
            check($sformatf("vec%0d_ce", i), {31'd0, cpu_ce}, {31'd0, tbl[i].exp_ce});
            check($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, tbl[i].exp_state});
        end
        check("after_vec_cnt", instr_cnt, 32'd2);
        step_btn = 1'b0;
        run_btn  = 1'b0;

        // Free-running: pulses every 4 cycles until ten have been issued
        for (int k = 0; k < 8; k++) begin
            wait_ce(10, n);
            if (k > 0) check("run_period", n, 32'd4);
        end
        cyc();
        check("run_cnt10", instr_cnt, 32'd10);
        press_run();
        check("pause_state", {30'd0, state}, 32'd0);
        ce_seen = 0;
        repeat (20) cyc();
        check("pause_no_ce", ce_seen, 32'd0);

        // Breakpoint at PC 0xC
        pc = 32'd0;
        bp_en = 1'b1;
        ce_seen = 0;
        press_run();
        repeat (34) cyc();
        check("bp_pulses", ce_seen, 32'd3);
        check("bp_state", {30'd0, state}, 32'd2);
        check("bp_cause", {30'd0, brk_cause}, 32'd1);
        check("bp_pc", pc, 32'h0000_000C);
        press_run();
        check("bp_resume_state", {30'd0, state}, 32'd1);
        check("bp_resume_cause", {30'd0, brk_cause}, 32'd0);
        wait_ce(10, n);
        check("bp_resume_pc", pc, 32'h0000_000C);
        wait_ce(10, n);
        check("bp_next_pc", pc, 32'h0000_0010);
        check("bp_running", {30'd0, state}, 32'd1);
        press_run();
        check("bp_pause", {30'd0, state}, 32'd0);
        bp_en = 1'b0;

        // Overflow halt after the first tick, then one step in BRK
        halt_on_of = 1'b1;
        press_run();
        wait_ce(10, n);
        of = 1'b1;
        ce_seen = 0;
        repeat (8) cyc();
        check("of_no_ce", ce_seen, 32'd0);
        check("of_state", {30'd0, state}, 32'd2);
        check("of_cause", {30'd0, brk_cause}, 32'd2);
        ce_seen = 0;
        press_step();
        repeat (4) cyc();
        check("brk_step_pulses", ce_seen, 32'd1);
        check("brk_step_state", {30'd0, state}, 32'd2);
        check("brk_step_cause", {30'd0, brk_cause}, 32'd2);
        of = 1'b0;
        halt_on_of = 1'b0;
        press_run();
        check("of_resume_state", {30'd0, state}, 32'd1);
        check("of_resume_cause", {30'd0, brk_cause}, 32'd0);

        // Reset one cycle before the next tick
        wait_ce(10, n);
        repeat (3) cyc();
        #1;
        rst = 1'b1;
        #1;
        check("arst_ce", {31'd0, cpu_ce}, 32'd0);
        check("arst_state", {30'd0, state}, 32'd0);
        check("arst_cause", {30'd0, brk_cause}, 32'd0);
        check("arst_cnt", instr_cnt, 32'd0);
        check("arst_cnt4", {28'd0, instr_cnt4}, 32'd0);
        ce_seen = 0;
        repeat (3) cyc();
        check("arst_no_ce", ce_seen, 32'd0);
        rst = 1'b0;
        ce_prev = 1'b0;
        pc = 32'd0;

        // Twenty steps: wide counter reaches 20, 4-bit counter sticks at 0xF
        ce_seen = 0;
        for (int k = 0; k < 20; k++) press_step();
        cyc();
        check("sat_pulses", ce_seen, 32'd20);
        check("sat_cnt32", instr_cnt, 32'd20);
        check("sat_cnt4", {28'd0, instr_cnt4}, 32'h0000_000F);
        check("sat_state", {30'd0, state}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
